// File: rtl/uart_alu_pkg.sv
// uart_alu_pkg: opcode and FSM state types plus the default UART prescale for uart_alu
package uart_alu_pkg;
   typedef enum logic [7:0] {
      OP_ADD = 8'h00,
      OP_SUB = 8'h01,
      OP_AND = 8'h02,
      OP_OR  = 8'h03,
      OP_XOR = 8'h04,
      OP_MUL = 8'h06
   } op_e;
   typedef enum logic [2:0] {
      S_IDLE, S_GET_A, S_GET_B, S_EXEC, S_SEND_LO, S_SEND_HI, S_SEND_ECHO
   } state_e;
   localparam logic [15:0] PRESCALE_DEF = 16'd9;
   function automatic logic is_op(input logic [7:0] b);
      return (b <= 8'h04) || (b == 8'h06);
   endfunction
endpackage

// File: rtl/uart_rx.sv
// uart_rx: 8N1 receiver, one valid_o pulse per byte whose stop bit is high
// ports: clk_i/rst_i clock and sync reset, rxd_i serial in, prescale_i bit period/8,
//        data_o received byte, valid_o one-cycle strobe
module uart_rx #(
   parameter int datawidth_p = 8
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   rxd_i,
   input  logic [15:0]            prescale_i,
   output logic [datawidth_p-1:0] data_o,
   output logic                   valid_o
);
   localparam int CW = $clog2(datawidth_p + 2);
   // sync_q[1] is the synchronised line, sync_q[2] its previous value
   logic [2:0]             sync_q;
   logic [datawidth_p-1:0] data_q;
   logic [CW-1:0]          idx_q;
   logic [18:0]            cyc_q;
   logic                   busy_q, valid_q;
   assign data_o  = data_q;
   assign valid_o = valid_q;
   // idx_q: 0 = start check, 1..datawidth_p = data bits, datawidth_p+1 = stop bit
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync_q  <= '1;
         data_q  <= '0;
         idx_q   <= '0;
         cyc_q   <= '0;
         busy_q  <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         sync_q  <= {sync_q[1:0], rxd_i};
         valid_q <= 1'b0;
         if (!busy_q) begin
            // falling edge only, so a low stop bit cannot retrigger a frame
            if (sync_q[2] && !sync_q[1]) begin
               busy_q <= 1'b1;
               idx_q  <= '0;
               cyc_q  <= {1'b0, prescale_i, 2'b0} - 19'd1;
            end
         end else if (cyc_q != 19'd0) begin
            cyc_q <= cyc_q - 19'd1;
         end else begin
            cyc_q <= {prescale_i, 3'b0} - 19'd1;
            idx_q <= idx_q + CW'(1);
            if (idx_q == '0)
               busy_q <= !sync_q[1];
            else if (idx_q <= CW'(datawidth_p))
               data_q <= {sync_q[1], data_q[datawidth_p-1:1]};
            else begin
               busy_q  <= 1'b0;
               valid_q <= sync_q[1];
            end
         end
      end
   end
endmodule

// File: rtl/uart_tx.sv
// uart_tx: 8N1 transmitter with an AXI-stream style byte input
// ports: clk/rst clock and sync reset, s_axis_tdata/tvalid/tready byte handshake,
//        txd serial out, busy frame in progress, prescale bit period/8
module uart_tx #(
   parameter int datawidth_p = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [datawidth_p-1:0] s_axis_tdata,
   input  logic                   s_axis_tvalid,
   output logic                   s_axis_tready,
   output logic                   txd,
   output logic                   busy,
   input  logic [15:0]            prescale
);
   localparam int CW = $clog2(datawidth_p + 2);
   // frame_q holds the bits still to send after the current one: data then stop
   logic [datawidth_p:0] frame_q;
   logic [CW-1:0]        bits_q;
   logic [18:0]          cyc_q;
   logic                 busy_q, txd_q;
   assign s_axis_tready = !busy_q;
   assign busy          = busy_q;
   assign txd           = txd_q;
   always_ff @(posedge clk) begin
      if (rst) begin
         frame_q <= '0;
         bits_q  <= '0;
         cyc_q   <= '0;
         busy_q  <= 1'b0;
         txd_q   <= 1'b1;
      end else if (!busy_q) begin
         if (s_axis_tvalid) begin
            frame_q <= {1'b1, s_axis_tdata};
            bits_q  <= CW'(datawidth_p + 1);
            cyc_q   <= {prescale, 3'b0} - 19'd1;
            busy_q  <= 1'b1;
            txd_q   <= 1'b0;
         end
      end else if (cyc_q != 19'd0) begin
         cyc_q <= cyc_q - 19'd1;
      end else if (bits_q != '0) begin
         txd_q   <= frame_q[0];
         frame_q <= frame_q >> 1;
         bits_q  <= bits_q - CW'(1);
         cyc_q   <= {prescale, 3'b0} - 19'd1;
      end else begin
         busy_q <= 1'b0;
      end
   end
endmodule

// File: rtl/uart_alu.sv
// uart_alu: UART-attached byte ALU; opcode,A,B packets answer result lo/hi, other bytes are echoed
// ports: clk_i clock, rst_i sync active-high reset, rx_i serial in, tx_o serial out (8N1)
module uart_alu
   import uart_alu_pkg::*;
#(
   parameter int          datawidth_p = 8,
   parameter logic [15:0] prescale_p  = PRESCALE_DEF
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic rx_i,
   output logic tx_o
);
   localparam int W = datawidth_p;
   logic [W-1:0]   rx_data, a_q, b_q, tdata_q;
   logic [2*W-1:0] res_q, res_d;
   logic           rx_valid, tx_ready, tx_busy, tvalid_q, accept;
   state_e         state_q;
   op_e            op_q;
   uart_rx #(.datawidth_p(W)) u_rx (
      .clk_i(clk_i), .rst_i(rst_i), .rxd_i(rx_i), .prescale_i(prescale_p),
      .data_o(rx_data), .valid_o(rx_valid)
   );
   uart_tx #(.datawidth_p(W)) u_tx (
      .clk(clk_i), .rst(rst_i), .s_axis_tdata(tdata_q), .s_axis_tvalid(tvalid_q),
      .s_axis_tready(tx_ready), .txd(tx_o), .busy(tx_busy), .prescale(prescale_p)
   );
   assign accept = tvalid_q && tx_ready && !tx_busy;
   always_comb begin
      res_d = '0;
      case (op_q)
         OP_ADD:  res_d = (2*W)'(a_q) + (2*W)'(b_q);
         OP_SUB:  res_d = {W'(a_q < b_q), a_q - b_q};
         OP_AND:  res_d = {W'(0), a_q & b_q};
         OP_OR:   res_d = {W'(0), a_q | b_q};
         OP_XOR:  res_d = {W'(0), a_q ^ b_q};
         OP_MUL:  res_d = (2*W)'(a_q) * (2*W)'(b_q);
         default: res_d = '0;
      endcase
   end
   // bytes arriving outside IDLE/GET_* are ignored, giving the drop-while-busy behaviour
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= S_IDLE;
         op_q     <= OP_ADD;
         a_q      <= '0;
         b_q      <= '0;
         res_q    <= '0;
         tdata_q  <= '0;
         tvalid_q <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: if (rx_valid) begin
               if (is_op(rx_data[7:0])) begin
                  op_q    <= op_e'(rx_data[7:0]);
                  state_q <= S_GET_A;
               end else begin
                  tdata_q  <= rx_data;
                  tvalid_q <= 1'b1;
                  state_q  <= S_SEND_ECHO;
               end
            end
            S_GET_A: if (rx_valid) begin
               a_q     <= rx_data;
               state_q <= S_GET_B;
            end
            S_GET_B: if (rx_valid) begin
               b_q     <= rx_data;
               state_q <= S_EXEC;
            end
            S_EXEC: begin
               res_q    <= res_d;
               tdata_q  <= res_d[W-1:0];
               tvalid_q <= 1'b1;
               state_q  <= S_SEND_LO;
            end
            S_SEND_LO: if (accept) begin
               tdata_q <= res_q[2*W-1:W];
               state_q <= S_SEND_HI;
            end
            S_SEND_HI, S_SEND_ECHO: if (accept) begin
               tvalid_q <= 1'b0;
               state_q  <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_uart_alu.sv
// tb_uart_alu: directed UART packets against a packet-level model of the ALU protocol
module tb_uart_alu;
   localparam int P8 = 72;
   logic clk = 1'b0, rst_i = 1'b1, rx_i = 1'b1, tx_o;
   int   cyc = 0, n_chk = 0, n_fail = 0, last_start = 0;
   int   exp_q[$], got_q[$], start_q[$], pkt[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   uart_alu #(.datawidth_p(8), .prescale_p(16'd9)) dut (
      .clk_i(clk), .rst_i(rst_i), .rx_i(rx_i), .tx_o(tx_o)
   );

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
      n_chk++;
      if (act < lo || act > hi) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d..%0d", nm, act, lo, hi);
      end
   endtask

   // packet-level model: opcode bytes start a 3-byte packet, anything else is echoed
   task automatic model_rx(input int b);
      int a, bb, r;
      if (pkt.size() == 0 && !(b inside {0, 1, 2, 3, 4, 6})) begin
         exp_q.push_back(b);
         return;
      end
      pkt.push_back(b);
      if (pkt.size() == 3) begin
         a  = pkt[1];
         bb = pkt[2];
         case (pkt[0])
            0: r = a + bb;
            1: r = ((a - bb) & 255) + ((a < bb) ? 256 : 0);
            2: r = a & bb;
            3: r = a | bb;
            4: r = a ^ bb;
            default: r = a * bb;
         endcase
         exp_q.push_back(r & 255);
         exp_q.push_back(r >> 8);
         pkt.delete();
      end
   endtask

   task automatic send_byte(input int b, input bit stop = 1'b1);
      @(negedge clk);
      rx_i = 1'b0;
      last_start = cyc;
      repeat (P8) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx_i = b[i];
         repeat (P8) @(negedge clk);
      end
      rx_i = stop;
      repeat (P8) @(negedge clk);
      rx_i = 1'b1;
   endtask

   task automatic run_pkt(input string nm, input int n, input int b0, input int b1, input int b2,
                          input int e0, input int e1);
      int bs[3];
      int ne, t;
      bs[0] = b0; bs[1] = b1; bs[2] = b2;
      ne = (n == 3) ? 2 : 1;
      for (int i = 0; i < n; i++) begin
         model_rx(bs[i]);
         send_byte(bs[i]);
      end
      t = 0;
      while ((exp_q.size() != 0 || got_q.size() < ne) && t < 4000) begin
         @(negedge clk);
         t++;
      end
      repeat (60) @(negedge clk);
      chk({nm, "_count"}, got_q.size(), ne);
      if (got_q.size() == ne) begin
         chk({nm, "_lo"}, got_q[0], e0);
         chk_rng({nm, "_latency"}, start_q[0] - last_start, 684, 696);
         if (ne == 2) begin
            chk({nm, "_hi"}, got_q[1], e1);
            chk_rng({nm, "_gap"}, start_q[1] - start_q[0], 720, 721);
         end
      end
      got_q.delete();
      start_q.delete();
   endtask

   // compare process: decode every tx frame and check it against the model queue
   initial begin
      int  st, d;
      bit  ab, sb, s0;
      forever begin
         @(negedge clk);
         if (!rst_i && tx_o === 1'b0) begin
            st = cyc;
            d  = 0;
            ab = 1'b0;
            repeat (35) begin @(negedge clk); ab |= rst_i; end
            s0 = tx_o;
            for (int i = 0; i < 8; i++) begin
               repeat (P8) begin @(negedge clk); ab |= rst_i; end
               d[i] = tx_o;
            end
            repeat (P8) begin @(negedge clk); ab |= rst_i; end
            sb = tx_o;
            if (!ab) begin
               chk("tx_start_bit", int'(s0), 0);
               chk("tx_stop_bit", int'(sb), 1);
               got_q.push_back(d);
               start_q.push_back(st);
               if (exp_q.size() == 0) begin
                  n_chk++;
                  n_fail++;
                  $display("FAIL tx_unexpected: got 0x%0h with no byte expected", d);
               end else
                  chk("tx_byte", d, exp_q.pop_front());
            end
         end
      end
   end

   initial begin
      repeat (95000) @(posedge clk);
      n_fail++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      repeat (5) begin @(negedge clk); chk("tx_in_reset", int'(tx_o), 1); end
      rst_i = 1'b0;
      repeat (2000) begin @(negedge clk); chk("tx_idle", int'(tx_o), 1); end
      run_pkt("echo_55", 1, 'h55, 0, 0, 'h55, 0);
      run_pkt("add_f0_20", 3, 'h00, 'hF0, 'h20, 'h10, 'h01);
      run_pkt("sub_10_20", 3, 'h01, 'h10, 'h20, 'hF0, 'h01);
      run_pkt("mul_ff_ff", 3, 'h06, 'hFF, 'hFF, 'h01, 'hFE);
      run_pkt("xor_aa_0f", 3, 'h04, 'hAA, 'h0F, 'hA5, 'h00);
      run_pkt("and_c3_3c", 3, 'h02, 'hC3, 'h3C, 'h00, 'h00);
      run_pkt("or_c3_3c", 3, 'h03, 'hC3, 'h3C, 'hFF, 'h00);
      run_pkt("add_ff_01", 3, 'h00, 'hFF, 'h01, 'h00, 'h01);
      run_pkt("sub_05_05", 3, 'h01, 'h05, 'h05, 'h00, 'h00);
      run_pkt("echo_05", 1, 'h05, 0, 0, 'h05, 0);
      // reset between operand bytes discards the partial packet
      model_rx('h00); send_byte('h00);
      model_rx('h01); send_byte('h01);
      @(negedge clk);
      rst_i = 1'b1;
      pkt.delete();
      exp_q.delete();
      repeat (3) @(negedge clk);
      chk("tx_in_mid_pkt_reset", int'(tx_o), 1);
      rst_i = 1'b0;
      run_pkt("reset_mid_pkt", 3, 'h00, 'h01, 'h02, 'h03, 'h00);
      // framing error: an ADD opcode with a low stop bit must leave the FSM idle
      send_byte('h00, 1'b0);
      repeat (1500) @(negedge clk);
      chk("ferr_silent", got_q.size(), 0);
      run_pkt("echo_after_ferr", 1, 'h55, 0, 0, 'h55, 0);
      // reset in the middle of a response frame
      model_rx('hA0);
      send_byte('hA0);
      repeat (100) @(negedge clk);
      chk("tx_active_before_abort", int'(tx_o), 0);
      rst_i = 1'b1;
      exp_q.delete();
      @(negedge clk);
      chk("tx_high_after_abort", int'(tx_o), 1);
      repeat (2) @(negedge clk);
      rst_i = 1'b0;
      repeat (1500) @(negedge clk);
      chk("abort_no_resume", got_q.size(), 0);
      chk("abort_tx_idle", int'(tx_o), 1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/uart_alu.md
UART_ALU -- requirements
Module: uart_alu

Interface
REQ-001 Parameter datawidth_p, default 8, SHALL set the UART data byte width and the ALU operand width.
REQ-002 Parameter prescale_p, default 16'd9, SHALL set the UART prescale; one bit period = prescale_p*8 clk_i cycles (72 at default).
REQ-003 clk_i  input  1  single clock; all logic is on its rising edge.
REQ-004 rst_i  input  1  reset, synchronous and active-high.
REQ-005 rx_i  input  1  UART serial in, 8N1, LSB first, idle high.
REQ-006 tx_o  output  1  UART serial out, 8N1, LSB first, idle high.

Function
REQ-007 RX path SHALL use a uart_rx instance to deliver one datawidth_p byte per valid stop bit; a byte with a framing error (stop bit low) SHALL be discarded.
REQ-008 TX path SHALL use a uart_tx instance with ports clk, rst, s_axis_tdata, s_axis_tvalid, s_axis_tready, txd, busy, prescale.
REQ-009 uart_tx: s_axis_tready high only when idle; a byte is accepted when tvalid&&tready; it then drives a start bit (0), 8 data bits LSB first, and a stop bit (1), each prescale*8 cycles; busy is high from acceptance to stop-bit end.
REQ-010 Opcodes: 0x00 ADD, 0x01 SUB, 0x02 AND, 0x03 OR, 0x04 XOR, 0x06 MUL; any other first byte is ECHO.
REQ-011 Packet for a valid opcode = opcode byte, then operand A, then operand B; the response SHALL be two bytes, result low then result high.
REQ-012 ADD: {hi,lo} = A+B (hi = carry, 0x00/0x01). SUB: lo = A-B mod 256, hi = 0x01 if A<B else 0x00. AND/OR/XOR: lo = bitwise result, hi = 0x00. MUL: {hi,lo} = A*B unsigned, 16 bits.
REQ-013 ECHO: the received byte SHALL be retransmitted unchanged as a single-byte response.
REQ-014 FSM states: IDLE, GET_A, GET_B, EXEC, SEND_LO, SEND_HI, SEND_ECHO. Transitions:
- IDLE->GET_A on a valid-opcode byte; IDLE->SEND_ECHO on any other byte.
- GET_A->GET_B on a byte; GET_B->EXEC on a byte.
- EXEC->SEND_LO after one cycle, registering the result.
- SEND_LO->SEND_HI on TX acceptance; SEND_HI->IDLE on TX acceptance; SEND_ECHO->IDLE on TX acceptance.
REQ-015 Bytes received while in EXEC/SEND_* states SHALL be dropped; no queueing.
REQ-016 Latency: the response start bit SHALL begin within 3 cycles after the stop-bit sample of the last received byte; the high byte SHALL follow back-to-back (no idle gap beyond one cycle).
REQ-017 There is no inter-byte timeout; a partial packet waits indefinitely until completed or until reset.

Reset
REQ-018 While rst_i is high, tx_o SHALL be 1, the FSM SHALL be in IDLE, and operand/result registers SHALL be 0; the uart_rx/uart_tx instances SHALL be reset by the same signal.
REQ-019 Reset asserted mid-packet or mid-transmission SHALL abort it; tx_o returns high in the next cycle.

Structure
REQ-020 Package uart_alu_pkg SHALL hold the opcode enum, the FSM state enum and the default prescale constant.
REQ-021 uart_tx and uart_rx SHALL be separate sub-modules instantiated by uart_alu; the ALU datapath SHALL be inline combinational logic.

Verification (prescale 9, 72-cycle bit period)
REQ-022 Reset, rx_i held high for 2000 cycles -> tx_o constantly 1.
REQ-023 Send 0x55 -> one frame on tx_o carrying 0x55 (alternating 1,0 bits LSB first), then idle.
REQ-024 Send 0x00,0xF0,0x20 -> response 0x10, 0x01; send 0x01,0x10,0x20 -> 0xF0, 0x01.
REQ-025 Send 0x06,0xFF,0xFF -> 0x01, 0xFE; send 0x04,0xAA,0x0F -> 0xA5, 0x00.
REQ-026 Send 0x00,0x01, then assert reset, then send 0x00,0x01,0x02 -> exactly one response 0x03, 0x00.
REQ-027 Send a byte with a low stop bit -> no response, FSM remains IDLE; a following 0x55 is echoed.
